// File: rtl/mult_nxn_cfg_pipe_pkg.sv
// Shared definitions for the configurable quadrant multiplier.
// Quadrant-mode encodings and q_mode field offsets.
package mult_nxn_cfg_pipe_pkg;

  typedef enum logic [1:0] {
    QM_EXACT = 2'b00,
    QM_TRUNC = 2'b01,
    QM_ZERO  = 2'b10,
    QM_RSVD  = 2'b11
  } qmode_e;

  localparam int QM_LL_LSB = 0;
  localparam int QM_LH_LSB = 2;
  localparam int QM_HL_LSB = 4;
  localparam int QM_HH_LSB = 6;

endpackage

// File: rtl/mult_nxn_cfg_pipe_quad.sv
// One H x H quadrant product with per-quadrant mode.
// Result width is 2H (= W of the enclosing multiplier).
module quad_mult_cfg
  import mult_nxn_cfg_pipe_pkg::*;
#(
  parameter int H     = 4,
  parameter int TRUNC = 2
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  input  logic [1:0]     mode,
  output logic [2*H-1:0] p
);

  logic [2*H-1:0] prod;
  logic [2*H-1:0] mask;

  assign prod = {{H{1'b0}}, a} * {{H{1'b0}}, b};
  assign mask = {(2*H){1'b1}} << TRUNC;

  always_comb begin
    p = prod;
    unique case (mode)
      QM_EXACT: p = prod;
      QM_TRUNC: p = prod & mask;
      QM_ZERO:  p = '0;
      QM_RSVD:  p = prod;
    endcase
  end

endmodule

// File: rtl/mult_nxn_cfg_pipe.sv
// Two-stage W x W multiplier built from four configurable quadrants.
// Stage 1 holds quadrant products, stage 2 holds the combined result.
module mult_nxn_cfg_pipe
  import mult_nxn_cfg_pipe_pkg::*;
#(
  parameter int W     = 8,
  parameter int TRUNC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [7:0]     q_mode,
  input  logic           comb_or,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] R
);

  localparam int H = W / 2;

  logic [W-1:0] c_ll, c_lh, c_hl, c_hh;
  logic [W-1:0] s1_ll, s1_lh, s1_hl, s1_hh;
  logic         s1_or;
  logic         s1_v;
  logic         s2_adv;
  logic         s1_load;

  quad_mult_cfg #(.H(H), .TRUNC(TRUNC)) u_ll (
    .a(A[H-1:0]), .b(B[H-1:0]),
    .mode(q_mode[QM_LL_LSB +: 2]), .p(c_ll)
  );
  quad_mult_cfg #(.H(H), .TRUNC(TRUNC)) u_lh (
    .a(A[H-1:0]), .b(B[W-1:H]),
    .mode(q_mode[QM_LH_LSB +: 2]), .p(c_lh)
  );
  quad_mult_cfg #(.H(H), .TRUNC(TRUNC)) u_hl (
    .a(A[W-1:H]), .b(B[H-1:0]),
    .mode(q_mode[QM_HL_LSB +: 2]), .p(c_hl)
  );
  quad_mult_cfg #(.H(H), .TRUNC(TRUNC)) u_hh (
    .a(A[W-1:H]), .b(B[W-1:H]),
    .mode(q_mode[QM_HH_LSB +: 2]), .p(c_hh)
  );

  // Stage 2 takes stage 1 when the output slot is empty or draining.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_v || s2_adv;
  assign s1_load  = in_valid && in_ready;

  logic [2*W:0]   e_ll, e_lh, e_hl, e_hh;
  logic [2*W:0]   sum;
  logic [2*W-1:0] ored;
  logic [2*W-1:0] comb;

  assign e_ll = {{(W+1){1'b0}}, s1_ll};
  assign e_lh = {{(W+1){1'b0}}, s1_lh} << H;
  assign e_hl = {{(W+1){1'b0}}, s1_hl} << H;
  assign e_hh = {{(W+1){1'b0}}, s1_hh} << W;
  assign sum  = e_ll + e_lh + e_hl + e_hh;
  assign ored = e_ll[2*W-1:0] | e_lh[2*W-1:0]
              | e_hl[2*W-1:0] | e_hh[2*W-1:0];
  assign comb = s1_or ? ored : sum[2*W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
    end else if (in_ready) begin
      s1_v <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_ll <= c_ll;
      s1_lh <= c_lh;
      s1_hl <= c_hl;
      s1_hh <= c_hh;
      s1_or <= comb_or;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      R         <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_v;
      if (s1_v) begin
        R <= comb;
      end
    end
  end

endmodule
